conware_axis_host: RTL and testbench
====================================

// Module: conware_axis_host
// PURPOSE
//  - AXI-Stream host that drives one Game-of-Life board into conware and collects the result.
//  - Transmits NUM_WORDS board words on M_AXIS (to conware's S_AXIS).
//  - Receives NUM_WORDS result words on S_AXIS (from conware's M_AXIS).
//  - Holds board and result buffers locally. Sits between the processor-side load/readback
//    logic and conware; used for hardware bring-up and throughput measurement.
// PARAMETERS
//  DATA_W     32   stream data width (bits); TKEEP/TSTRB width = DATA_W/8
//  NUM_WORDS  64   words per board (both directions), >= 2
//  ADDR_W     6    buffer address width, = clog2(NUM_WORDS)
// PORTS
//  ACLK           in   1        clock, all logic rising-edge
//  ARESETN        in   1        asynchronous active-low reset
//  start          in   1        1-cycle pulse: begin a transfer (honoured only in IDLE)
//  load_we        in   1        board buffer write enable (honoured only in IDLE)
//  load_addr      in   ADDR_W   board buffer write address
//  load_data      in   DATA_W   board buffer write data
//  rd_addr        in   ADDR_W   result buffer read address
//  rd_data        out  DATA_W   result word, registered, 1-cycle read latency
//  M_AXIS_TVALID  out  1        tx beat valid
//  M_AXIS_TDATA   out  DATA_W   tx data
//  M_AXIS_TLAST   out  1        tx last beat
//  M_AXIS_TREADY  in   1        tx accept
//  M_AXIS_TKEEP   out  DATA_W/8 tied all-ones
//  M_AXIS_TSTRB   out  DATA_W/8 tied all-ones
//  S_AXIS_TREADY  out  1        rx accept
//  S_AXIS_TDATA   in   DATA_W   rx data
//  S_AXIS_TLAST   in   1        rx last beat
//  S_AXIS_TVALID  in   1        rx beat valid
//  busy           out  1        high in SEND/RECV
//  done           out  1        1-cycle pulse when transfer completes
//  tlast_err      out  1        sticky TLAST framing error, cleared by accepted start
//  tx_count       out  32       cumulative accepted tx beats since reset, wraps at 2^32
//  rx_count       out  32       cumulative accepted rx beats since reset, wraps at 2^32
//  host_state     out  8        current FSM encoding, zero-extended
// BEHAVIOUR
//  - Reset (async assert, sync deassert inside design): state IDLE; all outputs 0
//    except TKEEP/TSTRB; tx_idx/rx_idx 0; buffers not cleared.
//  - FSM states and transitions:
//    - IDLE -> SEND on start. Clears tx_idx, rx_idx and tlast_err.
//    - SEND -> RECV when the beat with tx_idx==NUM_WORDS-1 is accepted.
//      Goes directly to DONE if all rx beats have already been accepted.
//    - RECV -> DONE when the beat with rx_idx==NUM_WORDS-1 is accepted.
//    - DONE -> IDLE after 1 cycle; done=1 during DONE only.
//  - TX:
//    - TVALID rises the cycle after start is sampled.
//    - Beat accepted on TVALID&&TREADY; TDATA = board[tx_idx].
//    - TDATA/TLAST held stable while TVALID&&!TREADY; TVALID never drops without acceptance.
//    - Back-to-back beats at 1/cycle under continuous TREADY.
//    - TLAST=1 only on tx_idx==NUM_WORDS-1.
//  - RX:
//    - S_AXIS_TREADY=1 in SEND and RECV, so overlapping rx during tx is allowed (no deadlock).
//    - Otherwise 0; extra beats beyond NUM_WORDS are back-pressured.
//    - Accepted beat is written to result[rx_idx], then rx_idx increments.
//    - tlast_err sets if TLAST=1 on rx_idx!=NUM_WORDS-1, or TLAST=0 on rx_idx==NUM_WORDS-1.
//      Transfer still completes after exactly NUM_WORDS beats.
//  - Simultaneous events:
//    - Tx and rx beats in the same cycle both count.
//    - Last tx and last rx in the same cycle -> DONE.
//    - start or load_we outside IDLE: ignored.
//    - rd_addr may be read at any time; reads during RECV return old or new data, no error.
//  - Counters: tx_count/rx_count increment per accepted beat and wrap silently.
//  - Reset mid-transfer: TVALID/TREADY drop immediately (async); next start resends from word 0.
// STRUCTURE
//  - conware_pkg: FSM state encodings (IDLE=0, SEND=1, RECV=2, DONE=3), DATA_W default,
//    KEEP_ALL constant.
//  - One sub-module: conware_word_ram.
//    - Simple dual-port, 1 write port, 1 async read port, DATA_W x NUM_WORDS.
//    - Instantiated twice: board buffer and result buffer.
//    - rd_data is registered in the top module.
// TESTING  (NUM_WORDS=4, DATA_W=32)
//  1. Load 0x1,0x2,0x3,0x4; start; TREADY=1 continuously
//     -> TDATA 1,2,3,4 on 4 consecutive cycles; TLAST on 4th only; tx_count=4.
//  2. As test 1 with TREADY alternating 0/1
//     -> each word held stable while stalled; no drop or duplicate; 4 beats total.
//  3. Rx 0xA,0xB,0xC,0xD with TLAST on 4th -> done pulses 1 cycle;
//     rd_addr=2 gives rd_data=0xC next cycle; tlast_err=0; rx_count=4.
//  4. Rx TLAST on beat 2 of 4 -> tlast_err=1 and stays 1 after done;
//     next start clears it to 0.
//  5. ARESETN=0 during tx beat 2 -> TVALID=0 without a clock edge; host_state=0;
//     counters 0; next start sends 0x1 first.
//  6. start and load_we (addr 0, 0xFF) while busy -> no restart; board[0] unchanged (0x1).

Source files
------------

// File: rtl/conware_pkg.sv
// Shared encodings and constants for the conware AXI-Stream host.
package conware_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } host_state_e;

  localparam int DATA_W_DEF = 32;

  // Wide enough for any stream width up to 512 bits; the top slices what it needs.
  localparam int KEEP_MAX_W = 64;
  localparam logic [KEEP_MAX_W-1:0] KEEP_ALL = '1;

endpackage

// File: rtl/conware_word_ram.sv
// Word buffer: one synchronous write port, one asynchronous read port.
module conware_word_ram #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conware_axis_host.sv
// Streams one board out on M_AXIS and collects the result board from S_AXIS.
//   state | meaning
//   IDLE  | buffers loadable, waiting for start
//   SEND  | transmitting board words (rx may already overlap)
//   RECV  | all tx done, waiting for remaining rx words
//   DONE  | one-cycle completion pulse
module conware_axis_host
  import conware_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic                load_we,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                M_AXIS_TVALID,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic [DATA_W/8-1:0] M_AXIS_TSTRB,
  output logic                S_AXIS_TREADY,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic                S_AXIS_TLAST,
  input  logic                S_AXIS_TVALID,
  output logic                busy,
  output logic                done,
  output logic                tlast_err,
  output logic [31:0]         tx_count,
  output logic [31:0]         rx_count,
  output logic [7:0]          host_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  host_state_e       state_q;
  logic [ADDR_W-1:0] tx_idx_q, rx_idx_q;
  logic              rx_done_q, tlast_err_q;
  logic [31:0]       tx_count_q, rx_count_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic              tx_fire, rx_fire, rx_last;
  logic [DATA_W-1:0] board_rd, result_rd;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign M_AXIS_TVALID = (state_q == ST_SEND);
  assign S_AXIS_TREADY = ((state_q == ST_SEND) || (state_q == ST_RECV)) && !rx_done_q;
  assign tx_fire       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign rx_fire       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign rx_last       = (rx_idx_q == LAST_IDX);

  conware_word_ram #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)) u_board (
    .clk_i   (ACLK),
    .we_i    (load_we && (state_q == ST_IDLE)),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (tx_idx_q),
    .rdata_o (board_rd)
  );

  conware_word_ram #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)) u_result (
    .clk_i   (ACLK),
    .we_i    (rx_fire),
    .waddr_i (rx_idx_q),
    .wdata_i (S_AXIS_TDATA),
    .raddr_i (rd_addr),
    .rdata_o (result_rd)
  );

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_idx_q    <= '0;
      rx_idx_q    <= '0;
      rx_done_q   <= 1'b0;
      tlast_err_q <= 1'b0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
    end else begin
      if (tx_fire) tx_count_q <= tx_count_q + 32'd1;
      if (rx_fire) begin
        rx_count_q <= rx_count_q + 32'd1;
        if (rx_last != S_AXIS_TLAST) tlast_err_q <= 1'b1;
        // Index parks on the last word; rx_done_q closes TREADY to stall extras.
        if (rx_last) rx_done_q <= 1'b1;
        else         rx_idx_q  <= rx_idx_q + ADDR_W'(1);
      end
      case (state_q)
        ST_IDLE: if (start) begin
          state_q     <= ST_SEND;
          tx_idx_q    <= '0;
          rx_idx_q    <= '0;
          rx_done_q   <= 1'b0;
          tlast_err_q <= 1'b0;
        end
        ST_SEND: if (tx_fire) begin
          if (tx_idx_q == LAST_IDX) begin
            if (rx_done_q || (rx_fire && rx_last)) state_q <= ST_DONE;
            else                                   state_q <= ST_RECV;
          end else begin
            tx_idx_q <= tx_idx_q + ADDR_W'(1);
          end
        end
        ST_RECV: if (rx_fire && rx_last) state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= result_rd;
  end

  assign rd_data      = rd_data_q;
  assign M_AXIS_TDATA = M_AXIS_TVALID ? board_rd : '0;
  assign M_AXIS_TLAST = M_AXIS_TVALID && (tx_idx_q == LAST_IDX);
  assign M_AXIS_TKEEP = KEEP_ALL[DATA_W/8-1:0];
  assign M_AXIS_TSTRB = KEEP_ALL[DATA_W/8-1:0];
  assign busy         = (state_q == ST_SEND) || (state_q == ST_RECV);
  assign done         = (state_q == ST_DONE);
  assign tlast_err    = tlast_err_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;
  assign host_state   = 8'(state_q);

endmodule

// File: tb/tb_conware_axis_host.sv
// Directed table-driven bench for conware_axis_host with a 4-word board.
module tb_conware_axis_host;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int AW = 2;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          start, load_we;
  logic [AW-1:0] load_addr, rd_addr;
  logic [DW-1:0] load_data, rd_data;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [3:0]    M_AXIS_TKEEP, M_AXIS_TSTRB;
  logic          S_AXIS_TREADY, S_AXIS_TLAST, S_AXIS_TVALID;
  logic [DW-1:0] S_AXIS_TDATA;
  logic          busy, done, tlast_err;
  logic [31:0]   tx_count, rx_count;
  logic [7:0]    host_state;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  conware_axis_host #(.DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID), .busy(busy), .done(done), .tlast_err(tlast_err),
    .tx_count(tx_count), .rx_count(rx_count), .host_state(host_state)
  );

  typedef struct {
    logic        start, lwe, tready, svalid;
    logic [31:0] sdata;
    logic        slast;
    logic        e_tvalid;
    logic [31:0] e_tdata;
    logic        e_tlast, e_sready, e_busy, e_done, e_err;
    logic [7:0]  e_state;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic lw, input logic tr, input logic sv,
                              input logic [31:0] sd, input logic sl, input logic etv,
                              input logic [31:0] etd, input logic etl, input logic esr,
                              input logic eb, input logic ed, input logic ee, input logic [7:0] es);
    vec_t v;
    v.start = st; v.lwe = lw; v.tready = tr; v.svalid = sv; v.sdata = sd; v.slast = sl;
    v.e_tvalid = etv; v.e_tdata = etd; v.e_tlast = etl; v.e_sready = esr;
    v.e_busy = eb; v.e_done = ed; v.e_err = ee; v.e_state = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; load_we = 0; load_addr = '0; load_data = '0;
    M_AXIS_TREADY = 0; S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 0;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic run_table(input string nm);
    logic [45:0] got, exp;
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; load_we = tbl[i].lwe;
      load_addr = '0; load_data = tbl[i].lwe ? 32'hFF : 32'h0;
      M_AXIS_TREADY = tbl[i].tready; S_AXIS_TVALID = tbl[i].svalid;
      S_AXIS_TDATA = tbl[i].sdata; S_AXIS_TLAST = tbl[i].slast;
      #1;
      got = {M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, S_AXIS_TREADY, busy, done, tlast_err, host_state};
      exp = {tbl[i].e_tvalid, tbl[i].e_tdata, tbl[i].e_tlast, tbl[i].e_sready,
             tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err, tbl[i].e_state};
      chk($sformatf("%s[%0d]", nm, i), 64'(got), 64'(exp));
      @(negedge ACLK);
    end
    clear_inputs();
    tbl.delete();
  endtask

  task automatic start_pulse();
    start = 1;
    @(negedge ACLK);
    start = 0;
  endtask

  task automatic read_result(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
    rd_addr = a;
    @(negedge ACLK);
    chk(nm, 64'(rd_data), 64'(exp));
  endtask

  task automatic release_reset();
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    repeat (4) @(negedge ACLK);
  endtask

  initial begin
    clear_inputs();
    rd_addr = '0;
    ARESETN = 1;
    #2 ARESETN = 0;
    #1;
    chk("rst_state",  64'(host_state), 64'h0);
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'h0);
    chk("rst_sready", 64'(S_AXIS_TREADY), 64'h0);
    chk("rst_keep",   64'({M_AXIS_TKEEP, M_AXIS_TSTRB}), 64'hFF);
    chk("rst_misc",   64'({busy, done, tlast_err, M_AXIS_TLAST}), 64'h0);
    chk("rst_counts", 64'({tx_count, rx_count}), 64'h0);
    chk("rst_rddata", 64'(rd_data), 64'h0);
    @(negedge ACLK);
    release_reset();

    for (int i = 0; i < NW; i++) begin
      load_we = 1; load_addr = AW'(i); load_data = 32'(i + 1);
      @(negedge ACLK);
    end
    load_we = 0;

    // Continuous TREADY, rx after tx
    start_pulse();
    tbl.push_back(mk(0,0,1,0,0,0,       1,1,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,2,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,3,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,4,1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,32'hA,0,   0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,32'hB,0,   0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,32'hC,0,   0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,32'hD,1,   0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,1,0,3));
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,0,0,0));
    run_table("t1");
    chk("t1_txcnt", 64'(tx_count), 64'd4);
    chk("t1_rxcnt", 64'(rx_count), 64'd4);
    chk("t1_err",   64'(tlast_err), 64'd0);
    read_result(2'd2, 32'hC, "t1_rd2");

    // Alternating TREADY, overlapped rx with early TLAST, extra beats back-pressured
    start_pulse();
    tbl.push_back(mk(0,0,0,1,32'hA,0,   1,1,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,1,32'hB,1,   1,1,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,32'hC,0,   1,2,0,1,1,0,1,1));
    tbl.push_back(mk(0,0,1,1,32'hD,0,   1,2,0,1,1,0,1,1));
    tbl.push_back(mk(0,0,0,1,32'hEE,0,  1,3,0,0,1,0,1,1));
    tbl.push_back(mk(0,0,1,1,32'hEE,1,  1,3,0,0,1,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,       1,4,1,0,1,0,1,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,4,1,0,1,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,1,1,3));
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,0,1,0));
    run_table("t2");
    chk("t2_txcnt", 64'(tx_count), 64'd8);
    chk("t2_rxcnt", 64'(rx_count), 64'd8);
    read_result(2'd1, 32'hB, "t2_rd1");
    read_result(2'd3, 32'hD, "t2_rd3");
    chk("t2_err_sticky", 64'(tlast_err), 64'd1);

    // Restart clears the error; reset during the second tx beat
    start_pulse();
    M_AXIS_TREADY = 1;
    #1;
    chk("t5_err_cleared", 64'(tlast_err), 64'd0);
    chk("t5_beat1", 64'({M_AXIS_TVALID, M_AXIS_TDATA}), {31'd0, 1'b1, 32'h1});
    @(negedge ACLK);
    #1;
    chk("t5_beat2", 64'({M_AXIS_TVALID, M_AXIS_TDATA}), {31'd0, 1'b1, 32'h2});
    ARESETN = 0;
    #1;
    chk("t5_async_tvalid", 64'({M_AXIS_TVALID, S_AXIS_TREADY, busy}), 64'h0);
    chk("t5_async_state",  64'(host_state), 64'h0);
    chk("t5_async_counts", 64'({tx_count, rx_count}), 64'h0);
    M_AXIS_TREADY = 0;
    @(negedge ACLK);
    release_reset();

    // start/load_we while busy are ignored; send restarts from word 0
    start_pulse();
    tbl.push_back(mk(1,1,0,0,0,0,       1,1,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,1,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,2,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,3,0,1,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,       1,4,1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,32'h5A,0,  0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,32'h5B,0,  0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,32'h5C,0,  0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,1,32'h5D,1,  0,0,0,1,1,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,1,0,3));
    tbl.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0,0,0,0));
    run_table("t6");
    chk("t6_txcnt", 64'(tx_count), 64'd4);
    chk("t6_rxcnt", 64'(rx_count), 64'd4);
    chk("t6_err",   64'(tlast_err), 64'd0);
    read_result(2'd0, 32'h5A, "t6_rd0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
